// File: rtl/axis_testpattern_checker.sv
// AXI4-Stream sink that checks a wrapping counter pattern and its burst framing.
// Counts accepted beats, data errors and TLAST errors; optionally throttles TREADY.
module axis_testpattern_checker #(
  parameter int unsigned S_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned S_AXIS_BURSTSIZE   = 16,
  parameter int          COUNTER_START      = 0,
  parameter int          COUNTER_END        = 255,
  parameter int          COUNTER_INCR       = 1,
  parameter int unsigned STALL_PERIOD       = 0
) (
  input  logic                          s_axis_aclk,
  input  logic                          s_axis_areset,
  input  logic                          enable,
  input  logic                          clr_counters,
  input  logic [S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  output logic                          locked,
  output logic                          err_pulse,
  output logic [31:0]                   beat_count,
  output logic [31:0]                   data_err_count,
  output logic [31:0]                   tlast_err_count
);

  localparam int unsigned W = S_AXIS_TDATA_WIDTH;
  localparam int unsigned PosW = (S_AXIS_BURSTSIZE > 1) ? $clog2(S_AXIS_BURSTSIZE) : 1;

  typedef logic signed [W-1:0] data_t;
  typedef enum logic [0:0] {StSync, StLocked} state_e;

  localparam data_t Incr    = data_t'(COUNTER_INCR);
  localparam data_t WrapAt  = data_t'(COUNTER_END - COUNTER_INCR + 1);
  localparam data_t WrapAdj = data_t'(COUNTER_INCR - (COUNTER_END - COUNTER_START) - 1);
  localparam logic [PosW-1:0] PosLast = PosW'(S_AXIS_BURSTSIZE - 1);

  function automatic data_t next_val(data_t x);
    return (x >= WrapAt) ? x + WrapAdj : x + Incr;
  endfunction

  function automatic logic [31:0] sat_inc(logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  state_e            state_q, state_d;
  data_t             expected_q, expected_d;
  logic              synced_q, synced_d;
  logic [PosW-1:0]   pos_q, pos_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;
  logic              tready_q, tready_d;
  logic              err_q, err_d;
  logic [31:0]       beat_q, beat_d, derr_q, derr_d, terr_q, terr_d;
  logic              accept, data_err, tlast_err, stall_hit;
  data_t             tdata_s;

  assign tdata_s = s_axis_tdata;
  assign accept  = s_axis_tvalid & tready_q;

  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    synced_d   = synced_q;
    pos_d      = pos_q;
    data_err   = 1'b0;
    tlast_err  = 1'b0;
    if (accept) begin
      case (state_q)
        StSync: begin
          state_d    = StLocked;
          expected_d = next_val(tdata_s);
        end
        StLocked: begin
          // A mismatch resyncs on the received value so a single slip costs one error.
          if (tdata_s == expected_q) begin
            expected_d = next_val(expected_q);
          end else begin
            data_err   = 1'b1;
            expected_d = next_val(tdata_s);
          end
        end
        default: state_d = StSync;
      endcase

      if (!synced_q) begin
        if (s_axis_tlast) begin
          synced_d = 1'b1;
          pos_d    = PosLast;
        end
      end else begin
        tlast_err = (s_axis_tlast != (pos_q == '0));
        if (s_axis_tlast) begin
          pos_d = PosLast;
        end else if (pos_q != '0) begin
          pos_d = pos_q - PosW'(1);
        end
      end
    end
  end

  always_comb begin
    stall_hit   = 1'b0;
    stall_cnt_d = stall_cnt_q;
    if (accept && (STALL_PERIOD != 0)) begin
      if (stall_cnt_q == STALL_PERIOD - 1) begin
        stall_hit   = 1'b1;
        stall_cnt_d = '0;
      end else begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
    end
    tready_d = enable & ~stall_hit;
    err_d    = accept & (data_err | tlast_err);

    beat_d = beat_q;
    derr_d = derr_q;
    terr_d = terr_q;
    // Clear takes priority over counting the beat accepted in the same cycle.
    if (clr_counters) begin
      beat_d = '0;
      derr_d = '0;
      terr_d = '0;
    end else if (accept) begin
      beat_d = sat_inc(beat_q);
      if (data_err)  derr_d = sat_inc(derr_q);
      if (tlast_err) terr_d = sat_inc(terr_q);
    end
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      state_q     <= StSync;
      expected_q  <= '0;
      synced_q    <= 1'b0;
      pos_q       <= '0;
      stall_cnt_q <= '0;
      tready_q    <= 1'b0;
      err_q       <= 1'b0;
      beat_q      <= '0;
      derr_q      <= '0;
      terr_q      <= '0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      synced_q    <= synced_d;
      pos_q       <= pos_d;
      stall_cnt_q <= stall_cnt_d;
      tready_q    <= tready_d;
      err_q       <= err_d;
      beat_q      <= beat_d;
      derr_q      <= derr_d;
      terr_q      <= terr_d;
    end
  end

  assign s_axis_tready   = tready_q;
  assign locked          = (state_q == StLocked);
  assign err_pulse       = err_q;
  assign beat_count      = beat_q;
  assign data_err_count  = derr_q;
  assign tlast_err_count = terr_q;

endmodule

// File: tb/tb_axis_testpattern_checker.sv
// Bench for axis_testpattern_checker: two configurations checked against a
// behavioural model of the pattern, framing, stall and counter rules.
module tb_axis_testpattern_checker;

  logic        clk = 1'b0;
  logic        rst[2], en[2], clr[2], valid[2], last[2];
  logic [31:0] data[2];
  logic        tready[2], locked[2], errp[2];
  logic [31:0] bc[2], dec[2], tec[2];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // u_dut0: 0..255 step 1, burst 16, no stall. u_dut1: 2..10 step 3, burst 4, stall every 3.
  axis_testpattern_checker #(
    .S_AXIS_TDATA_WIDTH(32), .S_AXIS_BURSTSIZE(16), .COUNTER_START(0),
    .COUNTER_END(255), .COUNTER_INCR(1), .STALL_PERIOD(0)
  ) u_dut0 (
    .s_axis_aclk(clk), .s_axis_areset(rst[0]), .enable(en[0]), .clr_counters(clr[0]),
    .s_axis_tdata(data[0]), .s_axis_tvalid(valid[0]), .s_axis_tlast(last[0]),
    .s_axis_tready(tready[0]), .locked(locked[0]), .err_pulse(errp[0]),
    .beat_count(bc[0]), .data_err_count(dec[0]), .tlast_err_count(tec[0])
  );

  axis_testpattern_checker #(
    .S_AXIS_TDATA_WIDTH(32), .S_AXIS_BURSTSIZE(4), .COUNTER_START(2),
    .COUNTER_END(10), .COUNTER_INCR(3), .STALL_PERIOD(3)
  ) u_dut1 (
    .s_axis_aclk(clk), .s_axis_areset(rst[1]), .enable(en[1]), .clr_counters(clr[1]),
    .s_axis_tdata(data[1]), .s_axis_tvalid(valid[1]), .s_axis_tlast(last[1]),
    .s_axis_tready(tready[1]), .locked(locked[1]), .err_pulse(errp[1]),
    .beat_count(bc[1]), .data_err_count(dec[1]), .tlast_err_count(tec[1])
  );

  // ---------------- reference model ----------------
  bit     m_locked[2], m_synced[2], m_err[2], m_tready[2], m_acc[2];
  int     m_exp[2], m_pos[2], m_since[2];
  longint m_beat[2], m_derr[2], m_terr[2];

  function automatic int nxt(int d, int x);
    int s = (d == 0) ? 0 : 2;
    int e = (d == 0) ? 255 : 10;
    int i = (d == 0) ? 1 : 3;
    return (x >= e - i + 1) ? x + i - (e - s) - 1 : x + i;
  endfunction

  task automatic model_step(int d);
    int burst = (d == 0) ? 16 : 4;
    int stall = (d == 0) ? 0 : 3;
    int x = $signed(data[d]);
    bit acc, de, te, stall_now;
    if (rst[d]) begin
      m_locked[d] = 0; m_synced[d] = 0; m_err[d] = 0; m_tready[d] = 0; m_acc[d] = 0;
      m_exp[d] = 0; m_pos[d] = 0; m_since[d] = 0;
      m_beat[d] = 0; m_derr[d] = 0; m_terr[d] = 0;
      return;
    end
    acc = valid[d] && m_tready[d];
    de = 0; te = 0; stall_now = 0;
    if (acc) begin
      if (!m_locked[d]) begin
        m_locked[d] = 1;
        m_exp[d] = nxt(d, x);
      end else begin
        de = (x != m_exp[d]);
        m_exp[d] = nxt(d, x);
      end
      if (!m_synced[d]) begin
        if (last[d]) begin m_synced[d] = 1; m_pos[d] = burst - 1; end
      end else begin
        te = (last[d] != (m_pos[d] == 0));
        m_pos[d] = last[d] ? burst - 1 : (m_pos[d] > 0 ? m_pos[d] - 1 : 0);
      end
      if (stall > 0) begin
        m_since[d]++;
        if (m_since[d] == stall) begin stall_now = 1; m_since[d] = 0; end
      end
    end
    if (clr[d]) begin
      m_beat[d] = 0; m_derr[d] = 0; m_terr[d] = 0;
    end else if (acc) begin
      if (m_beat[d] < 64'hFFFF_FFFF) m_beat[d]++;
      if (de && m_derr[d] < 64'hFFFF_FFFF) m_derr[d]++;
      if (te && m_terr[d] < 64'hFFFF_FFFF) m_terr[d]++;
    end
    m_err[d] = acc && (de || te);
    m_tready[d] = en[d] && !stall_now;
    m_acc[d] = acc;
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input int val, input bit tl);
    valid[d] = 1'b1;
    data[d] = 32'(val);
    last[d] = tl;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (m_acc[d]) break;
    end
    valid[d] = 1'b0;
    last[d] = 1'b0;
  endtask

  task automatic do_reset(input int d);
    rst[d] = 1'b1;
    tick();
    rst[d] = 1'b0;
    en[d] = 1'b1;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1; en[d] = 1; clr[d] = 0; valid[d] = 0; last[d] = 0; data[d] = '0;
    end
    tick(); tick();
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if ({tready[d], locked[d], errp[d]} !== 3'b000) begin
        miscompares++;
        $display("FAIL reset_flags d%0d: got %b want 000", d, {tready[d], locked[d], errp[d]});
      end
      vectors++;
      if ((bc[d] | dec[d] | tec[d]) !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_counts d%0d: got %0d/%0d/%0d want 0/0/0", d, bc[d], dec[d], tec[d]);
      end
      rst[d] = 0;
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (tready[d] !== 1'b1) begin
        miscompares++;
        $display("FAIL ready_after_reset d%0d: got %b want 1", d, tready[d]);
      end
    end
  endtask

  task automatic test_stream();
    int v = 0;
    do_reset(0);
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(3) == 0) tick();
      send(0, v, (i % 16) == 15);
      if (i == 0) begin
        vectors++;
        if (locked[0] !== 1'b1) begin
          miscompares++;
          $display("FAIL stream_lock: got %b want 1", locked[0]);
        end
      end
      v = nxt(0, v);
    end
    vectors++;
    if (bc[0] !== 32'd1000 || bc[0] !== 32'(m_beat[0])) begin
      miscompares++;
      $display("FAIL stream_beats: got %0d want 1000 (model %0d)", bc[0], m_beat[0]);
    end
    vectors++;
    if (dec[0] !== 32'd0 || tec[0] !== 32'd0) begin
      miscompares++;
      $display("FAIL stream_errs: got %0d/%0d want 0/0", dec[0], tec[0]);
    end
  endtask

  task automatic test_wrap();
    int v = 2;
    int tail[4] = '{3, 6, 9, 3};
    do_reset(1);
    for (int i = 0; i < 7; i++) begin
      send(1, v, (i % 4) == 3);
      v = nxt(1, v);
    end
    vectors++;
    if (dec[1] !== 32'd0 || locked[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_clean: got err %0d lock %b want 0 1", dec[1], locked[1]);
    end
    // 3 breaks the sequence once; 6,9,3 then follow from the resync.
    for (int i = 0; i < 4; i++) send(1, tail[i], ((i + 7) % 4) == 3);
    vectors++;
    if (dec[1] !== 32'd1 || dec[1] !== 32'(m_derr[1])) begin
      miscompares++;
      $display("FAIL wrap_resync: got %0d want 1 (model %0d)", dec[1], m_derr[1]);
    end
  endtask

  task automatic test_drop();
    int seq[4] = '{5, 6, 8, 9};
    bit want[4] = '{0, 0, 1, 0};
    do_reset(0);
    for (int i = 0; i < 4; i++) begin
      send(0, seq[i], 1'b0);
      vectors++;
      if (errp[0] !== want[i] || errp[0] !== m_err[0]) begin
        miscompares++;
        $display("FAIL drop_pulse beat %0d: got %b want %b", seq[i], errp[0], want[i]);
      end
    end
    tick();
    vectors++;
    if (dec[0] !== 32'd1 || errp[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_count: got %0d pulse %b want 1 0", dec[0], errp[0]);
    end
  endtask

  task automatic test_framing();
    int v = 2;
    do_reset(1);
    for (int i = 1; i <= 15; i++) begin
      send(1, v, (i == 4) || (i == 8) || (i == 11) || (i == 15));
      v = nxt(1, v);
    end
    // Early TLAST at 11 reloads the position, so 15 lands exactly on the next burst end.
    vectors++;
    if (tec[1] !== 32'd1 || tec[1] !== 32'(m_terr[1]) || dec[1] !== 32'd0) begin
      miscompares++;
      $display("FAIL framing_directed: got %0d/%0d want 1/0", tec[1], dec[1]);
    end
    for (int i = 0; i < 40; i++) begin
      send(1, v, $urandom_range(3) == 0);
      v = nxt(1, v);
    end
    vectors++;
    if (tec[1] !== 32'(m_terr[1]) || bc[1] !== 32'(m_beat[1])) begin
      miscompares++;
      $display("FAIL framing_random: got %0d/%0d want %0d/%0d", tec[1], bc[1], m_terr[1],
               m_beat[1]);
    end
  endtask

  task automatic test_stall();
    int v = 2;
    bit rec[24];
    int bad = 0;
    do_reset(1);
    valid[1] = 1'b1;
    data[1] = 32'(v);
    for (int c = 0; c < 24; c++) begin
      tick();
      rec[c] = tready[1];
      vectors++;
      if (tready[1] !== m_tready[1]) begin
        miscompares++;
        $display("FAIL stall_ready cycle %0d: got %b want %b", c, tready[1], m_tready[1]);
      end
      if (m_acc[1]) begin
        v = nxt(1, v);
        data[1] = 32'(v);
      end
    end
    valid[1] = 1'b0;
    for (int i = 0; i + 3 < 24; i++) begin
      if (int'(!rec[i]) + int'(!rec[i+1]) + int'(!rec[i+2]) + int'(!rec[i+3]) != 1) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL stall_pattern: got %0d bad windows want 0", bad);
    end
    vectors++;
    if (dec[1] !== 32'd0 || bc[1] !== 32'(m_beat[1])) begin
      miscompares++;
      $display("FAIL stall_data: got err %0d beats %0d want 0 %0d", dec[1], bc[1], m_beat[1]);
    end
  endtask

  task automatic test_enable();
    do_reset(0);
    send(0, 40, 1'b0);
    valid[0] = 1'b1;
    data[0] = 32'd41;
    en[0] = 1'b0;
    tick();
    vectors++;
    if (tready[0] !== 1'b0 || bc[0] !== 32'd2) begin
      miscompares++;
      $display("FAIL enable_drop: got ready %b beats %0d want 0 2", tready[0], bc[0]);
    end
    tick();
    vectors++;
    if (bc[0] !== 32'd2 || bc[0] !== 32'(m_beat[0])) begin
      miscompares++;
      $display("FAIL enable_hold: got %0d want 2", bc[0]);
    end
    valid[0] = 1'b0;
    en[0] = 1'b1;
    tick();
  endtask

  task automatic test_clr_reset();
    do_reset(0);
    for (int i = 0; i < 3; i++) send(0, i, 1'b0);
    clr[0] = 1'b1;
    send(0, 7, 1'b0);
    clr[0] = 1'b0;
    vectors++;
    if ((bc[0] | dec[0] | tec[0]) !== 32'd0 || errp[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_same_cycle: got %0d/%0d/%0d pulse %b want 0/0/0 1", bc[0], dec[0],
               tec[0], errp[0]);
    end
    send(0, 8, 1'b0);
    send(0, 9, 1'b0);
    vectors++;
    if (bc[0] !== 32'd2 || dec[0] !== 32'd0) begin
      miscompares++;
      $display("FAIL clr_followup: got %0d/%0d want 2/0", bc[0], dec[0]);
    end
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    vectors++;
    if (locked[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_lock: got %b want 0", locked[0]);
    end
    tick();
    send(0, 100, 1'b0);
    send(0, 101, 1'b0);
    vectors++;
    if (locked[0] !== 1'b1 || dec[0] !== 32'd0 || bc[0] !== 32'd2 || errp[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL relock: got lock %b err %0d beats %0d pulse %b want 1 0 2 0", locked[0],
               dec[0], bc[0], errp[0]);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wrap();
    test_drop();
    test_framing();
    test_stall();
    test_enable();
    test_clr_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
